// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared constants and types for the ULA multiply/divide path.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    localparam logic [5:0] OP_ARIT    = 6'b000000;
    localparam logic [5:0] FUNCT_MULT = 6'b000010;
    localparam logic [5:0] FUNCT_DIV  = 6'b000011;
    localparam int         N_ITER     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_estado_t;

    function automatic logic funct_valido(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_muldiv_passo.sv
`default_nettype none
// ============================================================================
// Module      : ula_muldiv_passo
// Description : One combinational step of shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_muldiv_passo (
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_q,
    input  logic [31:0] i_d,
    output logic [63:0] o_acc,
    output logic [31:0] o_q
);

    logic [32:0] w_soma;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;

    always_comb begin
        w_soma   = {1'b0, i_acc[63:32]} + (i_q[0] ? {1'b0, i_d} : 33'd0);
        w_rem_sh = {i_acc[31:0], i_q[31]};
        w_trial  = w_rem_sh - {1'b0, i_d};
        if (i_div) begin
            // A set sign bit means the trial went negative: keep the shifted remainder.
            o_acc = {32'd0, (w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0])};
            o_q   = {i_q[30:0], ~w_trial[32]};
        end else begin
            o_acc = {w_soma, i_acc[31:1]};
            o_q   = {1'b0, i_q[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ula_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : ula_muldiv_seq
// Description : 32-step iterative unsigned MULT/DIV sequencer with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_muldiv_seq
    import ula_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        Inicio,
    input  logic [5:0]  funct,
    input  logic [31:0] Dados_1,
    input  logic [31:0] Dados_2,
    output logic        Ocupado,
    output logic        Pronto,
    output logic [31:0] Resultado,
    output logic [31:0] Resto,
    output logic        DivZero
);

    muldiv_estado_t r_estado;
    muldiv_estado_t w_estado_nxt;
    logic [5:0]     r_cnt;
    logic [63:0]    r_acc;
    logic [31:0]    r_q;
    logic [31:0]    r_d;
    logic           r_dz_pend;
    logic [31:0]    r_resultado;
    logic [31:0]    r_resto;
    logic           r_divzero;

    logic [63:0]    w_acc_nxt;
    logic [31:0]    w_q_nxt;
    logic           w_aceita;
    logic           w_ativo;
    logic           w_ultimo;

    assign w_aceita = ((r_estado == IDLE) || (r_estado == DONE)) && Inicio && funct_valido(funct);
    assign w_ativo  = (r_estado == MUL) || (r_estado == DIV);
    assign w_ultimo = (r_cnt == 6'(N_ITER - 1));

    ula_muldiv_passo u_passo (
        .i_div (r_estado == DIV),
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_d   (r_d),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt)
    );

    always_comb begin
        w_estado_nxt = r_estado;
        case (r_estado)
            IDLE, DONE: begin
                if (w_aceita)
                    w_estado_nxt = (funct == FUNCT_MULT) ? MUL : DIV;
                else
                    w_estado_nxt = IDLE;
            end
            MUL:     if (w_ultimo) w_estado_nxt = DONE;
            DIV:     if (r_dz_pend || w_ultimo) w_estado_nxt = DONE;
            default: w_estado_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= IDLE;
            r_cnt       <= 6'd0;
            r_acc       <= 64'd0;
            r_q         <= 32'd0;
            r_d         <= 32'd0;
            r_dz_pend   <= 1'b0;
            r_resultado <= 32'd0;
            r_resto     <= 32'd0;
            r_divzero   <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            if (w_aceita) begin
                r_cnt     <= 6'd0;
                r_acc     <= 64'd0;
                r_divzero <= 1'b0;
                r_dz_pend <= (funct == FUNCT_DIV) && (Dados_2 == 32'd0);
                if (funct == FUNCT_MULT) begin
                    r_q <= Dados_2;
                    r_d <= Dados_1;
                end else begin
                    r_q <= Dados_1;
                    r_d <= Dados_2;
                end
            end else if ((r_estado == DIV) && r_dz_pend) begin
                // Zero divisor: r_q still holds the untouched dividend.
                r_resultado <= 32'hFFFF_FFFF;
                r_resto     <= r_q;
                r_divzero   <= 1'b1;
                r_dz_pend   <= 1'b0;
            end else if (w_ativo) begin
                r_acc <= w_acc_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt + 6'd1;
                if (w_ultimo) begin
                    if (r_estado == MUL) begin
                        r_resultado <= w_acc_nxt[31:0];
                        r_resto     <= w_acc_nxt[63:32];
                    end else begin
                        r_resultado <= w_q_nxt;
                        r_resto     <= w_acc_nxt[31:0];
                    end
                end
            end
        end
    end

    assign Ocupado   = (r_estado == MUL) || ((r_estado == DIV) && !r_dz_pend);
    assign Pronto    = (r_estado == DONE);
    assign Resultado = r_resultado;
    assign Resto     = r_resto;
    assign DivZero   = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_ula_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_muldiv_seq
// Description : Self-checking bench for ula_muldiv_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ula_muldiv_seq;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        Inicio  = 1'b0;
    logic [5:0]  funct   = 6'd0;
    logic [31:0] Dados_1 = 32'd0;
    logic [31:0] Dados_2 = 32'd0;
    logic        Ocupado;
    logic        Pronto;
    logic [31:0] Resultado;
    logic [31:0] Resto;
    logic        DivZero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ula_muldiv_seq dut (
        .clock     (clock),
        .reset     (reset),
        .Inicio    (Inicio),
        .funct     (funct),
        .Dados_1   (Dados_1),
        .Dados_2   (Dados_2),
        .Ocupado   (Ocupado),
        .Pronto    (Pronto),
        .Resultado (Resultado),
        .Resto     (Resto),
        .DivZero   (DivZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nome, act, exp, $time);
        end
    endtask

    // Behavioural model: results from plain * / %, timing from a countdown.
    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
    mst_t        m_st     = M_IDLE;
    int          m_left   = 0;
    bit          m_hidden = 1'b0;
    logic [31:0] m_res    = 32'd0;
    logic [31:0] m_resto  = 32'd0;
    logic        m_dz     = 1'b0;
    logic [31:0] p_res    = 32'd0;
    logic [31:0] p_resto  = 32'd0;
    logic        p_dz     = 1'b0;
    logic [63:0] prod;

    always @(posedge clock) begin
        if (reset) begin
            m_st = M_IDLE; m_res = 0; m_resto = 0; m_dz = 0; m_hidden = 0;
        end else if ((m_st == M_IDLE || m_st == M_DONE) && Inicio &&
                     (funct == 6'b000010 || funct == 6'b000011)) begin
            m_dz = 1'b0;
            m_st = M_RUN;
            if (funct == 6'b000010) begin
                prod = {32'd0, Dados_1} * {32'd0, Dados_2};
                p_res = prod[31:0]; p_resto = prod[63:32]; p_dz = 0; m_left = 32; m_hidden = 0;
            end else if (Dados_2 == 32'd0) begin
                p_res = 32'hFFFF_FFFF; p_resto = Dados_1; p_dz = 1; m_left = 1; m_hidden = 1;
            end else begin
                p_res = Dados_1 / Dados_2; p_resto = Dados_1 % Dados_2; p_dz = 0; m_left = 32; m_hidden = 0;
            end
        end else if (m_st == M_RUN) begin
            m_left--;
            if (m_left == 0) begin
                m_st = M_DONE; m_res = p_res; m_resto = p_resto; m_dz = p_dz;
            end
        end else if (m_st == M_DONE) begin
            m_st = M_IDLE;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model Ocupado",   Ocupado,   (m_st == M_RUN) && !m_hidden);
            check("model Pronto",    Pronto,    m_st == M_DONE);
            check("model Resultado", Resultado, m_res);
            check("model Resto",     Resto,     m_resto);
            check("model DivZero",   DivZero,   m_dz);
        end
    end

    // Starts an op (accept at the next edge), scrambles operands afterwards and
    // waits for Pronto; exp_n = edges after the accept edge until Pronto shows.
    task automatic run_op(input string nome, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int segura, input int exp_n,
                          input logic [31:0] er, input logic [31:0] erst, input logic edz);
        int n;
        logic viu;
        Inicio = 1'b1; funct = f; Dados_1 = a; Dados_2 = b;
        @(posedge clock); #1;
        Inicio = (segura > 0);
        Dados_1 = $urandom; Dados_2 = $urandom;
        n = 0; viu = 1'b0;
        while (!Pronto && n < 40) begin
            if (Ocupado) viu = 1'b1;
            @(posedge clock); n++; #1;
            if (n >= segura) Inicio = 1'b0;
        end
        Inicio = 1'b0;
        check({nome, " latency"},   n,         exp_n);
        check({nome, " Resultado"}, Resultado, er);
        check({nome, " Resto"},     Resto,     erst);
        check({nome, " DivZero"},   DivZero,   edz);
        check({nome, " Ocupado seen"}, viu,    exp_n > 1);
    endtask

    initial begin
        int npronto;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        check("reset Ocupado",   Ocupado,   0);
        check("reset Pronto",    Pronto,    0);
        check("reset Resultado", Resultado, 0);
        check("reset Resto",     Resto,     0);
        check("reset DivZero",   DivZero,   0);

        run_op("mul 7x6",   6'b000010, 32'd7, 32'd6, 0, 32, 32'h0000002A, 32'h0, 1'b0);
        repeat (3) @(posedge clock); #1;
        run_op("mul ffx2",  6'b000010, 32'hFFFF_FFFF, 32'd2, 0, 32, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run_op("div 100/7 held", 6'b000011, 32'd100, 32'd7, 10, 32, 32'd14, 32'd2, 1'b0);
        run_op("div ff/1",  6'b000011, 32'hFFFF_FFFF, 32'd1, 0, 32, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("div 100/0", 6'b000011, 32'd100, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'd100, 1'b1);
        run_op("mul 3x5",   6'b000010, 32'd3, 32'd5, 0, 32, 32'd15, 32'd0, 1'b0);
        run_op("b2b div 9/2", 6'b000011, 32'd9, 32'd2, 0, 32, 32'd4, 32'd1, 1'b0);

        @(posedge clock); #1;
        Inicio = 1'b1; funct = 6'b000000; Dados_1 = 32'd5; Dados_2 = 32'd5;
        repeat (4) begin
            @(posedge clock); #1;
            check("bad funct Ocupado", Ocupado, 0);
            check("bad funct Pronto",  Pronto,  0);
        end
        Inicio = 1'b0;

        Inicio = 1'b1; funct = 6'b000010; Dados_1 = 32'd11; Dados_2 = 32'd13;
        @(posedge clock); #1;
        Inicio = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset Ocupado",   Ocupado,   0);
        check("midreset Resultado", Resultado, 0);
        check("midreset Resto",     Resto,     0);
        check("midreset DivZero",   DivZero,   0);
        npronto = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (Pronto) npronto++;
        end
        check("midreset no Pronto", npronto, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
